draw_sequencer: RTL and testbench

Sequences all writes into the 160x120 `vga_adapter` frame buffer, which has a single write port. It arbitrates between two requesters: a full-screen background redraw and a 20x10 hit/note sprite draw at a requested position. For each granted request it walks the source ROM, compensates for ROM read latency, and drives one pixel per cycle on `x`/`y`/`colour`/`plot`. It replaces the free-running sweep counters and the static image mux.

---
 rtl/taiko_draw_pkg.sv | 34 +++
 rtl/raster_walker.sv | 41 ++++
 rtl/draw_sequencer.sv | 161 ++++++++++++++++
 tb/tb_draw_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taiko_draw_pkg.sv
// Shared constants, FSM state type and pipeline tag for the frame-buffer draw sequencer.
package taiko_draw_pkg;

    localparam int unsigned SCREEN_W   = 160;
    localparam int unsigned SCREEN_H   = 120;
    localparam int unsigned SPR_W      = 20;
    localparam int unsigned SPR_H      = 10;
    localparam int unsigned COLOR_W    = 3;
    localparam int unsigned BG_PIXELS  = SCREEN_W * SCREEN_H;
    localparam int unsigned SPR_PIXELS = SPR_W * SPR_H;

    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned BG_ADDR_W  = 15;
    localparam int unsigned SPR_ADDR_W = 8;

    localparam logic [COLOR_W-1:0] KEY_COLOR = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BG    = 2'd1,
        SPR   = 2'd2,
        DRAIN = 2'd3
    } draw_state_t;

    // Coordinates and plot qualifier travelling alongside a ROM read.
    typedef struct packed {
        logic           valid;
        logic           spr;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_tag_t;

endpackage

// File: rtl/raster_walker.sv
// Row-major raster walker: linear ROM address plus paired (x, y), one step per cycle.
module raster_walker #(
    parameter int unsigned W = 160,
    parameter int unsigned H = 120,
    localparam int unsigned XW = $clog2(W),
    localparam int unsigned YW = $clog2(H),
    localparam int unsigned AW = $clog2(W * H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          last
);

    assign last = (addr == AW'(W * H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (start) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (step) begin
            addr <= addr + AW'(1);
            if (x == XW'(W - 1)) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Arbitrates background/sprite redraws onto the single frame-buffer write port.
// Build option: DRAW_SEQ_SPR_KEY_EN suppresses sprite pixels equal to KEY_COLOR.
module draw_sequencer
    import taiko_draw_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  bg_req,
    input  logic                  bg_sel,
    output logic                  bg_ack,
    input  logic                  spr_req,
    input  logic [X_W-1:0]        spr_x,
    input  logic [Y_W-1:0]        spr_y,
    output logic                  spr_ack,
    output logic [BG_ADDR_W-1:0]  bg_addr,
    output logic                  bg_src,
    input  logic [COLOR_W-1:0]    bg_color,
    output logic [SPR_ADDR_W-1:0] spr_addr,
    input  logic [COLOR_W-1:0]    spr_color,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [COLOR_W-1:0]    vga_colour,
    output logic                  vga_plot,
    output logic                  busy
);

    draw_state_t    state;
    logic           drain_cnt;
    logic [X_W-1:0] spr_x_q;
    logic [Y_W-1:0] spr_y_q;

    logic [X_W-1:0] bg_x;
    logic [Y_W-1:0] bg_y;
    logic           bg_last;
    logic [4:0]     spr_dx;
    logic [3:0]     spr_dy;
    logic           spr_last;

    logic           bg_start, bg_step, spr_start, spr_step;
    logic [8:0]     tgt_x;
    logic [7:0]     tgt_y;
    logic           in_bounds;
    logic           keyed;
    pix_tag_t       pipe;

    assign bg_start  = (state == IDLE) && bg_req;
    assign spr_start = (state == IDLE) && !bg_req && spr_req;
    assign bg_step   = (state == BG)  && !bg_last;
    assign spr_step  = (state == SPR) && !spr_last;

    raster_walker #(.W(SCREEN_W), .H(SCREEN_H)) u_bg_walker (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .start (bg_start),
        .step  (bg_step),
        .x     (bg_x),
        .y     (bg_y),
        .addr  (bg_addr),
        .last  (bg_last)
    );

    raster_walker #(.W(SPR_W), .H(SPR_H)) u_spr_walker (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .start (spr_start),
        .step  (spr_step),
        .x     (spr_dx),
        .y     (spr_dy),
        .addr  (spr_addr),
        .last  (spr_last)
    );

    // Widened target so a sprite hanging off the right/bottom edge is detectable.
    assign tgt_x     = 9'(spr_x_q) + 9'(spr_dx);
    assign tgt_y     = 8'(spr_y_q) + 8'(spr_dy);
    assign in_bounds = (tgt_x < 9'(SCREEN_W)) && (tgt_y < 8'(SCREEN_H));

`ifdef DRAW_SEQ_SPR_KEY_EN
    assign keyed = pipe.spr && (spr_color == KEY_COLOR);
`else
    assign keyed = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            bg_ack    <= 1'b0;
            spr_ack   <= 1'b0;
            bg_src    <= 1'b0;
            spr_x_q   <= '0;
            spr_y_q   <= '0;
            busy      <= 1'b0;
        end else begin
            bg_ack  <= 1'b0;
            spr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bg_req) begin
                        bg_ack <= 1'b1;
                        bg_src <= bg_sel;
                        busy   <= 1'b1;
                        state  <= BG;
                    end else if (spr_req) begin
                        spr_ack <= 1'b1;
                        spr_x_q <= spr_x;
                        spr_y_q <= spr_y;
                        busy    <= 1'b1;
                        state   <= SPR;
                    end
                end
                BG: begin
                    if (bg_last) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                SPR: begin
                    if (spr_last) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Two cycles: ROM stage then output register.
                    if (drain_cnt) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag stage aligned with ROM data, then registered frame-buffer port.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pipe       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            if (state == BG) begin
                pipe <= '{valid: 1'b1, spr: 1'b0, x: bg_x, y: bg_y};
            end else if (state == SPR) begin
                pipe <= '{valid: in_bounds, spr: 1'b1, x: tgt_x[X_W-1:0], y: tgt_y[Y_W-1:0]};
            end else begin
                pipe <= '0;
            end
            vga_x      <= pipe.x;
            vga_y      <= pipe.y;
            vga_colour <= pipe.spr ? spr_color : bg_color;
            vga_plot   <= pipe.valid && !keyed;
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: table-driven jobs, random sprites, arbitration and reset corner cases.
module tb_draw_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        bg_req, bg_sel, spr_req;
    logic [7:0]  spr_x;
    logic [6:0]  spr_y;
    logic [2:0]  bg_color, spr_color;
    logic        bg_ack, spr_ack, bg_src, vga_plot, busy;
    logic [14:0] bg_addr;
    logic [7:0]  spr_addr, vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } pix_t;

    typedef struct {
        bit is_bg;
        bit sel;
        int sx;
        int sy;
        int exp_plots;
        int exp_plots_key;
    } vec_t;

    pix_t got_q[$];
    pix_t exp_q[$];
    logic [2:0] spr_rom [256];

    draw_sequencer dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .bg_req     (bg_req),
        .bg_sel     (bg_sel),
        .bg_ack     (bg_ack),
        .spr_req    (spr_req),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_ack    (spr_ack),
        .bg_addr    (bg_addr),
        .bg_src     (bg_src),
        .bg_color   (bg_color),
        .spr_addr   (spr_addr),
        .spr_color  (spr_color),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [2:0] bg_rom(input logic sel, input int a);
        return 3'((a * 5) + (a >> 7) + (sel ? 3 : 0));
    endfunction

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge CLOCK_50) begin
        bg_color  <= bg_rom(bg_src, int'(bg_addr));
        spr_color <= spr_rom[spr_addr];
    end

    always @(negedge CLOCK_50) begin
        if (resetn === 1'b1 && vga_plot === 1'b1)
            got_q.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour), cyc});
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint all_outs();
        return longint'({bg_ack, spr_ack, bg_addr, bg_src, spr_addr,
                         vga_x, vga_y, vga_colour, vga_plot, busy});
    endfunction

    task automatic add_bg_model(input bit sel);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back('{x, y, int'(bg_rom(sel, y * 160 + x)), 0});
    endtask

    task automatic add_spr_model(input int sx, input int sy);
        for (int dy = 0; dy < 10; dy++) begin
            for (int dx = 0; dx < 20; dx++) begin
                int c;
                bit keep;
                c = int'(spr_rom[dy * 20 + dx]);
                keep = (sx + dx < 160) && (sy + dy < 120);
`ifdef DRAW_SEQ_SPR_KEY_EN
                if (c == 0) keep = 1'b0;
`endif
                if (keep) exp_q.push_back('{sx + dx, sy + dy, c, 0});
            end
        end
    endtask

    task automatic cmp_stream(input string name);
        int bad = 0;
        int first = -1;
        int n;
        n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || i >= exp_q.size() ||
                got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].c != exp_q[i].c) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            if (first < got_q.size() && first < exp_q.size())
                $display("FAIL %s_pixels bad=%0d idx=%0d actual=(%0d,%0d,c%0d) expected=(%0d,%0d,c%0d)",
                         name, bad, first, got_q[first].x, got_q[first].y, got_q[first].c,
                         exp_q[first].x, exp_q[first].y, exp_q[first].c);
            else
                $display("FAIL %s_pixels bad=%0d actual_len=%0d expected_len=%0d",
                         name, bad, got_q.size(), exp_q.size());
        end
    endtask

    task automatic wait_ack(input bit is_bg, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge CLOCK_50);
            if (is_bg ? bg_ack : spr_ack) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int exp_busy);
        int n = 0;
        while (busy && n < 25000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk({name, "_busy_cycles"}, n, exp_busy);
    endtask

    task automatic run_job(input bit is_bg, input bit sel, input int sx, input int sy,
                           input int exp_plots, input string name);
        bit ok;
        int ack_cyc;
        repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
        got_q.delete();
        exp_q.delete();
        if (is_bg) add_bg_model(sel);
        else add_spr_model(sx, sy);
        if (is_bg) begin
            bg_sel = sel;
            bg_req = 1'b1;
        end else begin
            spr_x   = 8'(sx);
            spr_y   = 7'(sy);
            spr_req = 1'b1;
        end
        wait_ack(is_bg, ok);
        chk({name, "_ack"}, longint'(ok), 1);
        bg_req  = 1'b0;
        spr_req = 1'b0;
        if (!ok) return;
        ack_cyc = cyc;
        // Scramble request-side inputs: the job must use values latched at grant.
        bg_sel = ~sel;
        spr_x  = 8'($urandom);
        spr_y  = 7'($urandom);
        if (is_bg) chk({name, "_bg_src"}, longint'(bg_src), longint'(sel));
        wait_idle(name, is_bg ? 19202 : 202);
        repeat (3) @(negedge CLOCK_50);
        if (exp_plots >= 0) chk({name, "_plot_count"}, got_q.size(), exp_plots);
        cmp_stream(name);
        if (is_bg && got_q.size() > 0) chk({name, "_first_latency"}, got_q[0].t - ack_cyc, 2);
    endtask

    initial begin
        vec_t vecs [7];
        bit   ok;
        int   n;
        int   found;
        int   found_c;

        vecs[0] = '{1'b1, 1'b1, 0,   0,   19200, 19200};
        vecs[1] = '{1'b0, 1'b0, 120, 100, 200,   199};
        vecs[2] = '{1'b0, 1'b0, 150, 115, 50,    49};
        vecs[3] = '{1'b0, 1'b0, 0,   0,   200,   199};
        vecs[4] = '{1'b0, 1'b0, 159, 119, 1,     1};
        vecs[5] = '{1'b0, 1'b0, 255, 127, 0,     0};
        vecs[6] = '{1'b1, 1'b0, 0,   0,   19200, 19200};

        for (int i = 0; i < 256; i++) spr_rom[i] = 3'($urandom_range(1, 7));
        spr_rom[5] = 3'b000;

        resetn  = 1'b0;
        bg_req  = 1'b0;
        bg_sel  = 1'b0;
        spr_req = 1'b0;
        spr_x   = '0;
        spr_y   = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_outputs", all_outs(), 0);
        resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("idle_outputs", all_outs(), 0);

        for (int i = 0; i < 7; i++) begin
`ifdef DRAW_SEQ_SPR_KEY_EN
            n = vecs[i].exp_plots_key;
`else
            n = vecs[i].exp_plots;
`endif
            run_job(vecs[i].is_bg, vecs[i].sel, vecs[i].sx, vecs[i].sy, n, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++)
            run_job(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), -1,
                    $sformatf("rand%0d", i));

        // Transparent-key pixel: ROM index 5 is colour 0, lands at (45, 30).
        run_job(1'b0, 1'b0, 40, 30, -1, "key");
        found = 0;
        found_c = -1;
        foreach (got_q[i]) if (got_q[i].x == 45 && got_q[i].y == 30) begin
            found++;
            found_c = got_q[i].c;
        end
`ifdef DRAW_SEQ_SPR_KEY_EN
        chk("key_pixel_plotted", found, 0);
`else
        chk("key_pixel_plotted", found, 1);
        chk("key_pixel_colour", found_c, 0);
`endif

        // Simultaneous requests: background first, sprite granted after its drain.
        @(negedge CLOCK_50);
        got_q.delete();
        exp_q.delete();
        add_bg_model(1'b0);
        add_spr_model(10, 20);
        bg_sel  = 1'b0;
        spr_x   = 8'd10;
        spr_y   = 7'd20;
        bg_req  = 1'b1;
        spr_req = 1'b1;
        wait_ack(1'b1, ok);
        chk("sim_bg_ack", longint'(ok), 1);
        chk("sim_spr_ack_held", longint'(spr_ack), 0);
        bg_req = 1'b0;
        n = 0;
        while (!spr_ack && n < 25000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("sim_grant_to_grant", n, 19203);
        spr_req = 1'b0;
        wait_idle("sim_spr", 202);
        repeat (3) @(negedge CLOCK_50);
        cmp_stream("sim");

        // Reset 1000 cycles into a background job.
        got_q.delete();
        bg_sel = 1'b1;
        bg_req = 1'b1;
        wait_ack(1'b1, ok);
        chk("rst_bg_ack", longint'(ok), 1);
        bg_req = 1'b0;
        repeat (1000) @(negedge CLOCK_50);
        chk("rst_prejob_plotting", longint'(got_q.size() > 900), 1);
        resetn = 1'b0;
        #1;
        chk("rst_async_outputs", all_outs(), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        got_q.delete();
        repeat (100) @(negedge CLOCK_50);
        chk("rst_no_plots_after", got_q.size(), 0);
        chk("rst_busy_after", longint'(busy), 0);

        run_job(1'b0, 1'b0, 70, 50, -1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
